// File: rtl/mult_shift_add_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// The master drives start and the operands. The slave returns the product and status.
interface mult_shift_add_if #(
  parameter int unsigned N = 4
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;

  modport master (output start, a, b, input product, busy, done);
  modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/mult_shift_add.sv
// Unsigned N x N sequential multiplier: one shared ripple adder and one add+shift per cycle.
// Registered 2N-bit product with a one-cycle done pulse.

// Plain ripple-carry adder; carry-out is not needed because callers widen operands by one bit.
module suma #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] s
);
  logic [W-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i] = x[i] ^ y[i] ^ c[i];
    if (i < W - 1) begin : g_carry
      assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end
endmodule

module mult_shift_add #(
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst,
  mult_shift_add_if.slave bus
);
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  acc_lo;
  logic [CW-1:0] count;

  logic [N:0]    add_op;
  logic [N:0]    sum_full;
  logic          c;
  logic [N-1:0]  sum;

  // The adder is one bit wider than the operands, so the carry lands in the top bit and is never lost.
  assign add_op = acc_lo[0] ? {1'b0, mcand} : '0;

  suma #(.W(N + 1)) u_suma (
    .x ({1'b0, acc_hi}),
    .y (add_op),
    .s (sum_full)
  );

  assign c   = sum_full[N];
  assign sum = sum_full[N-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      count       <= '0;
      bus.product <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          if (bus.start) begin
            mcand    <= bus.a;
            acc_hi   <= '0;
            acc_lo   <= bus.b;
            count    <= CW'(N);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end

        RUN: begin
          acc_hi <= {c, sum[N-1:1]};
          acc_lo <= {sum[0], acc_lo[N-1:1]};
          count  <= count - CW'(1);
          // Last iteration: publish the shifted accumulator directly so it is visible during DONE.
          if (count == CW'(1)) begin
            bus.product <= {c, sum, acc_lo[N-1:1]};
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_shift_add.sv
// Scoreboard bench for mult_shift_add with N=4 and N=8 instances.
// Stimulus pushes hand-computed products. A negedge monitor pops and compares them on each done.
module tb_mult_shift_add;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_shift_add_if #(.N(4)) if4 ();
  mult_shift_add_if #(.N(8)) if8 ();

  mult_shift_add #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  mult_shift_add #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  logic [7:0]  q4[$];
  logic [15:0] q8[$];
  logic [7:0]  last4;
  logic [7:0]  e4;
  logic [15:0] e8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (if4.done === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done4: product 0x%0h with empty queue", if4.product);
      end else begin
        e4 = q4.pop_front();
        check("product4", 32'(if4.product), 32'(e4));
      end
    end
    if (if8.done === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done8: product 0x%0h with empty queue", if8.product);
      end else begin
        e8 = q8.pop_front();
        check("product8", 32'(if8.product), 32'(e8));
      end
    end
  end

  // One N=4 operation. glitch >= 0 pulses a bogus start in that RUN cycle (0 = first RUN cycle).
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                     input int glitch);
    int n;
    int bc;
    @(negedge clk);
    if4.a = a; if4.b = b; if4.start = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    if4.start = 1'b0;
    if4.a = 4'($urandom); if4.b = 4'($urandom);
    check("hold_product4", 32'(if4.product), 32'(last4));
    n = 0; bc = 0;
    while (if4.done !== 1'b1 && n < 20) begin
      if (if4.busy === 1'b1) bc++;
      if (n == glitch) begin
        if4.start = 1'b1; if4.a = 4'd1; if4.b = 4'd1;
      end else begin
        if4.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    if4.start = 1'b0;
    check("latency4", 32'(n), 32'd4);
    check("busy_cycles4", 32'(bc), 32'd4);
    last4 = exp;
    @(negedge clk);
    check("done_pulse4", 32'(if4.done), 32'd0);
    check("idle4", 32'(if4.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t[3];
    rst = 1'b1;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    last4 = '0;
    repeat (2) @(negedge clk);
    check("rst_product4", 32'(if4.product), 32'd0);
    check("rst_busy4", 32'(if4.busy), 32'd0);
    check("rst_done4", 32'(if4.done), 32'd0);
    check("rst_product8", 32'(if8.product), 32'd0);
    rst = 1'b0;

    op4(4'd3, 4'd5, 8'h0F, -1);
    op4(4'd15, 4'd15, 8'hE1, -1);
    op4(4'd13, 4'd11, 8'h8F, -1);
    op4(4'd0, 4'd9, 8'h00, -1);
    op4(4'd9, 4'd0, 8'h00, -1);
    op4(4'd6, 4'd7, 8'h2A, 1);
    repeat (3) @(negedge clk);

    // Reset in the third RUN cycle discards the operation.
    if4.a = 4'd12; if4.b = 4'd10; if4.start = 1'b1;
    @(negedge clk); if4.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy4", 32'(if4.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy4", 32'(if4.busy), 32'd0);
    check("midrst_done4", 32'(if4.done), 32'd0);
    check("midrst_product4", 32'(if4.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last4 = '0;
    repeat (6) @(negedge clk);
    check("post_rst_idle4", 32'(if4.busy), 32'd0);
    op4(4'd2, 4'd3, 8'h06, -1);

    // Reset and start together: reset wins and nothing starts.
    @(negedge clk);
    rst = 1'b1; if4.start = 1'b1; if4.a = 4'd5; if4.b = 4'd5;
    @(negedge clk);
    rst = 1'b0; if4.start = 1'b0;
    @(negedge clk);
    check("rst_start_busy4", 32'(if4.busy), 32'd0);
    check("rst_start_product4", 32'(if4.product), 32'd0);

    // N=8 with start held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    if8.a = 8'd255; if8.b = 8'd255; if8.start = 1'b1;
    repeat (3) q8.push_back(16'hFE01);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      while (if8.done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      t[k] = cyc;
      if (k == 0) check("first_latency8", 32'(n), 32'd9);
      if (k == 2) if8.start = 1'b0;
      @(negedge clk);
      n = 0;
    end
    check("spacing8_a", 32'(t[1] - t[0]), 32'd10);
    check("spacing8_b", 32'(t[2] - t[1]), 32'd10);
    repeat (12) @(negedge clk);
    check("idle8", 32'(if8.busy), 32'd0);

    check("q4_drained", 32'(q4.size()), 32'd0);
    check("q8_drained", 32'(q8.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
